// File: rtl/mul_issue_seq_if.sv
// Operand, multiplier-control and result signals of the mul_issue_seq operand sequencer.
// master = sequencer side, slave = environment (operand source, multiplier, result sink).
interface mul_issue_seq_if #(
    parameter int WIDTH = 16
);
    logic             op_valid;
    logic             op_ready;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;

    logic             mul_start;
    logic [WIDTH-1:0] mul_bus;
    logic             mul_rst_n;
    logic             mul_done;
    logic [WIDTH-1:0] mul_prod;

    logic             res_valid;
    logic             res_ready;
    logic [WIDTH-1:0] res_prod;
    logic             res_timeout;

    modport master (
        input  op_valid, op_a, op_b, mul_done, mul_prod, res_ready,
        output op_ready, mul_start, mul_bus, mul_rst_n, res_valid, res_prod, res_timeout
    );

    modport slave (
        output op_valid, op_a, op_b, mul_done, mul_prod, res_ready,
        input  op_ready, mul_start, mul_bus, mul_rst_n, res_valid, res_prod, res_timeout
    );
endinterface

// File: rtl/mul_issue_seq.sv
// Sequences (A,B) pairs onto a repeated-addition multiplier, waits for done under a watchdog
// and returns the product; define MUL_ZERO_BYPASS_EN to answer zero operands without the multiplier.
module mul_issue_seq #(
    parameter int WIDTH      = 16,
    parameter int TIMEOUT    = 70000,
    parameter int RST_CYCLES = 2
) (
    input logic             clk,
    input logic             rst_n,
    mul_issue_seq_if.master ifc
);
    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam int RC_W  = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_LOAD_A,
        S_LOAD_B,
        S_WAIT,
        S_RESULT,
        S_REARM
    } state_e;

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [RC_W-1:0]    rc_q, rc_d;

    logic               mul_start_q, mul_start_d;
    logic [WIDTH-1:0]   mul_bus_q, mul_bus_d;
    logic               mul_rst_n_q, mul_rst_n_d;
    logic               res_valid_q, res_valid_d;
    logic [WIDTH-1:0]   res_prod_q, res_prod_d;
    logic               res_timeout_q, res_timeout_d;

    logic               accept;
    logic               zero_op;

    assign ifc.op_ready    = (state_q == S_IDLE) && mul_rst_n_q;
    assign ifc.mul_start   = mul_start_q;
    assign ifc.mul_bus     = mul_bus_q;
    assign ifc.mul_rst_n   = mul_rst_n_q;
    assign ifc.res_valid   = res_valid_q;
    assign ifc.res_prod    = res_prod_q;
    assign ifc.res_timeout = res_timeout_q;

    assign accept = ifc.op_valid && (state_q == S_IDLE) && mul_rst_n_q;

`ifdef MUL_ZERO_BYPASS_EN
    assign zero_op = (ifc.op_a == '0) || (ifc.op_b == '0);
`else
    assign zero_op = 1'b0;
`endif

    always_comb begin
        state_d       = state_q;
        a_d           = a_q;
        b_d           = b_q;
        cnt_d         = cnt_q;
        rc_d          = rc_q;
        res_prod_d    = res_prod_q;
        res_timeout_d = res_timeout_q;

        unique case (state_q)
            S_IDLE: begin
                if (accept) begin
                    a_d = ifc.op_a;
                    b_d = ifc.op_b;
                    if (zero_op) begin
                        res_prod_d    = '0;
                        res_timeout_d = 1'b0;
                        state_d       = S_RESULT;
                    end else begin
                        state_d       = S_START;
                    end
                end
            end
            S_START:  state_d = S_LOAD_A;
            S_LOAD_A: state_d = S_LOAD_B;
            S_LOAD_B: begin
                cnt_d   = '0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                cnt_d = cnt_q + CNT_W'(1);
                // done takes priority over a watchdog expiring in the same cycle
                if (ifc.mul_done) begin
                    res_prod_d    = ifc.mul_prod;
                    res_timeout_d = 1'b0;
                    state_d       = S_RESULT;
                end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                    res_prod_d    = '0;
                    res_timeout_d = 1'b1;
                    state_d       = S_RESULT;
                end
            end
            S_RESULT: begin
                if (ifc.res_ready) begin
                    rc_d    = '0;
                    state_d = S_REARM;
                end
            end
            S_REARM: begin
                if (rc_q == RC_W'(RST_CYCLES - 1)) begin
                    state_d = S_IDLE;
                end else begin
                    rc_d = rc_q + RC_W'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Outputs are registered versions of what the next state presents.
        mul_start_d = (state_d == S_START);
        mul_rst_n_d = (state_d != S_REARM);
        res_valid_d = (state_d == S_RESULT);
        if (state_d == S_LOAD_A) begin
            mul_bus_d = a_d;
        end else if (state_d == S_LOAD_B) begin
            mul_bus_d = b_d;
        end else begin
            mul_bus_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= S_IDLE;
            a_q           <= '0;
            b_q           <= '0;
            cnt_q         <= '0;
            rc_q          <= '0;
            mul_start_q   <= 1'b0;
            mul_bus_q     <= '0;
            mul_rst_n_q   <= 1'b0;
            res_valid_q   <= 1'b0;
            res_prod_q    <= '0;
            res_timeout_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            a_q           <= a_d;
            b_q           <= b_d;
            cnt_q         <= cnt_d;
            rc_q          <= rc_d;
            mul_start_q   <= mul_start_d;
            mul_bus_q     <= mul_bus_d;
            mul_rst_n_q   <= mul_rst_n_d;
            res_valid_q   <= res_valid_d;
            res_prod_q    <= res_prod_d;
            res_timeout_q <= res_timeout_d;
        end
    end
endmodule

// File: tb/tb_mul_issue_seq.sv
// Directed and random jobs for mul_issue_seq; the bench plays operand source, multiplier and result sink.
module tb_mul_issue_seq;
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    mul_issue_seq_if #(.WIDTH(16)) m_if ();
    mul_issue_seq_if #(.WIDTH(16)) t_if ();

    mul_issue_seq #(.WIDTH(16), .TIMEOUT(70000), .RST_CYCLES(2)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .ifc   (m_if.master)
    );

    mul_issue_seq #(.WIDTH(16), .TIMEOUT(16), .RST_CYCLES(2)) dut_t (
        .clk   (clk),
        .rst_n (rst_n),
        .ifc   (t_if.master)
    );

    int n_assert = 0;
    int n_fail   = 0;
    int starts_seen = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
        if (m_if.mul_start === 1'b1) starts_seen++;
    endtask

    // One complete job on the main instance, starting at a negedge where op_ready is high.
    task automatic do_job(input logic [15:0] a, input logic [15:0] b, input int lat,
                          input int hold, input bit keep);
        logic [15:0] ca, cb, exp;
        bit byp;
        int starts0, lowc, guard;
        exp = 16'(32'(a) * 32'(b));
        byp = 1'b0;
`ifdef MUL_ZERO_BYPASS_EN
        byp = (a == 16'd0) || (b == 16'd0);
`endif
        starts0 = starts_seen;
        chk("op_ready_idle", 32'(m_if.op_ready), 1);
        m_if.op_valid = 1'b1;
        m_if.op_a = a;
        m_if.op_b = b;
        step();
        m_if.op_valid = keep;
        m_if.op_a = 16'($urandom);
        m_if.op_b = 16'($urandom);
        chk("op_ready_busy", 32'(m_if.op_ready), 0);
        if (!byp) begin
            chk("start_hi", 32'(m_if.mul_start), 1);
            chk("bus_start", 32'(m_if.mul_bus), 0);
            step();
            chk("start_lo", 32'(m_if.mul_start), 0);
            chk("bus_a", 32'(m_if.mul_bus), 32'(a));
            ca = m_if.mul_bus;
            step();
            chk("bus_b", 32'(m_if.mul_bus), 32'(b));
            cb = m_if.mul_bus;
            step();
            chk("bus_wait", 32'(m_if.mul_bus), 0);
            for (int i = 0; i < lat; i++) step();
            chk("no_early_result", 32'(m_if.res_valid), 0);
            m_if.mul_done = 1'b1;
            m_if.mul_prod = 16'(32'(ca) * 32'(cb));
            step();
        end else begin
            chk("bypass_bus", 32'(m_if.mul_bus), 0);
        end
        chk("res_valid", 32'(m_if.res_valid), 1);
        chk("res_prod", 32'(m_if.res_prod), 32'(exp));
        chk("res_timeout", 32'(m_if.res_timeout), 0);
        for (int i = 0; i < hold; i++) begin
            step();
            chk("hold_valid", 32'(m_if.res_valid), 1);
            chk("hold_prod", 32'(m_if.res_prod), 32'(exp));
            chk("hold_op_ready", 32'(m_if.op_ready), 0);
        end
        m_if.res_ready = 1'b1;
        step();
        m_if.res_ready = 1'b0;
        chk("res_valid_drop", 32'(m_if.res_valid), 0);
        if (m_if.mul_rst_n === 1'b0) begin
            m_if.mul_done = 1'b0;
            m_if.mul_prod = 16'd0;
        end
        lowc = 0;
        guard = 0;
        while (m_if.mul_rst_n !== 1'b1 && guard < 10) begin
            lowc++;
            step();
            guard++;
        end
        chk("rearm_len", 32'(lowc), 2);
        chk("op_ready_back", 32'(m_if.op_ready), 1);
        chk("start_count", 32'(starts_seen - starts0), byp ? 0 : 1);
    endtask

    initial begin
        int wc;
        rst_n = 1'b0;
        m_if.op_valid = 1'b0; m_if.op_a = '0; m_if.op_b = '0;
        m_if.mul_done = 1'b0; m_if.mul_prod = '0; m_if.res_ready = 1'b0;
        t_if.op_valid = 1'b0; t_if.op_a = '0; t_if.op_b = '0;
        t_if.mul_done = 1'b0; t_if.mul_prod = '0; t_if.res_ready = 1'b0;

        // reset state
        step(); step(); step();
        chk("rst_start", 32'(m_if.mul_start), 0);
        chk("rst_bus", 32'(m_if.mul_bus), 0);
        chk("rst_mul_rst_n", 32'(m_if.mul_rst_n), 0);
        chk("rst_res_valid", 32'(m_if.res_valid), 0);
        chk("rst_res_prod", 32'(m_if.res_prod), 0);
        chk("rst_res_timeout", 32'(m_if.res_timeout), 0);
        chk("rst_op_ready", 32'(m_if.op_ready), 0);
        rst_n = 1'b1;
        step();
        chk("rel_mul_rst_n", 32'(m_if.mul_rst_n), 1);
        chk("rel_op_ready", 32'(m_if.op_ready), 1);

        do_job(16'd3, 16'd5, 2, 0, 1'b0);
        do_job(16'd300, 16'd300, 5, 10, 1'b0);

        // done while idle is ignored
        m_if.mul_done = 1'b1;
        m_if.mul_prod = 16'd77;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("idle_done_ignored", 32'(m_if.res_valid), 0);
        end
        m_if.mul_done = 1'b0;
        m_if.mul_prod = 16'd0;

        // reset during WAIT drops the job
        m_if.op_valid = 1'b1; m_if.op_a = 16'd9; m_if.op_b = 16'd9;
        step();
        m_if.op_valid = 1'b0;
        step(); step(); step(); step(); step();
        rst_n = 1'b0;
        step();
        chk("midrst_mul_rst_n", 32'(m_if.mul_rst_n), 0);
        chk("midrst_res_valid", 32'(m_if.res_valid), 0);
        chk("midrst_op_ready", 32'(m_if.op_ready), 0);
        rst_n = 1'b1;
        step();
        chk("midrst_op_ready_after", 32'(m_if.op_ready), 1);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("midrst_no_result", 32'(m_if.res_valid), 0);
        end
        do_job(16'd2, 16'd4, 3, 0, 1'b0);

        do_job(16'd0, 16'd7, 4, 1, 1'b0);

        // back-to-back with op_valid held high
        do_job(16'd1, 16'd1, 0, 0, 1'b1);
        do_job(16'd65535, 16'd2, 1, 0, 1'b1);
        do_job(16'd7, 16'd9, 2, 0, 1'b1);
        m_if.op_valid = 1'b0;

        for (int i = 0; i < 10; i++) begin
            logic [15:0] ra, rb;
            ra = 16'($urandom);
            rb = 16'($urandom);
            if (i == 3) ra = 16'd0;
            if (i == 6) rb = 16'd0;
            do_job(ra, rb, int'($urandom_range(0, 12)), int'($urandom_range(0, 3)), 1'b0);
        end

        // watchdog on the TIMEOUT=16 instance
        t_if.op_valid = 1'b1; t_if.op_a = 16'd5; t_if.op_b = 16'd6;
        step();
        t_if.op_valid = 1'b0;
        step(); step(); step();
        wc = 0;
        while (t_if.res_valid !== 1'b1 && wc < 40) begin
            step();
            wc++;
        end
        chk("timeout_latency", 32'(wc), 16);
        chk("timeout_prod", 32'(t_if.res_prod), 0);
        chk("timeout_flag", 32'(t_if.res_timeout), 1);
        t_if.res_ready = 1'b1;
        step();
        t_if.res_ready = 1'b0;
        step(); step();
        chk("timeout_op_ready", 32'(t_if.op_ready), 1);

        // done in the last watchdog cycle wins
        t_if.op_valid = 1'b1; t_if.op_a = 16'd5; t_if.op_b = 16'd6;
        step();
        t_if.op_valid = 1'b0;
        step(); step(); step();
        for (int i = 0; i < 15; i++) step();
        chk("edge_no_result", 32'(t_if.res_valid), 0);
        t_if.mul_done = 1'b1;
        t_if.mul_prod = 16'd30;
        step();
        chk("edge_valid", 32'(t_if.res_valid), 1);
        chk("edge_prod", 32'(t_if.res_prod), 30);
        chk("edge_timeout", 32'(t_if.res_timeout), 0);
        t_if.res_ready = 1'b1;
        step();
        t_if.res_ready = 1'b0;
        t_if.mul_done = 1'b0;
        step(); step();
        chk("edge_op_ready", 32'(t_if.op_ready), 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
